// File: rtl/multicycle_seq_pkg.sv
// Shared constants for the multi-cycle RV32I control sequencer: state encoding,
// reset IR value and register-file write-source selects.
package multicycle_seq_pkg;

    localparam logic [2:0] S_BOOT   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

    // Only the low two address bits decide word alignment of a jump target.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/multicycle_seq_if.sv
// Sequencer-side bundle: memory handshakes, decoder/ALU inputs and the
// architectural state exported to the datapath. master = sequencer.
interface multicycle_seq_if;

    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    logic        dec_is_load;
    logic        dec_is_store;
    logic        dec_reg_we;
    logic        dec_is_ecall;

    logic        br_taken;
    logic [31:0] alu_result;
    logic [31:0] br_target;

    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] alu_out;
    logic [31:0] mdr;
    logic        wb_sel;
    logic        rf_we;
    logic        retire;
    logic        halted;
    logic        fault;

    modport master (
        output imem_req,
        input  imem_ack, imem_rdata,
        output dmem_req, dmem_we,
        input  dmem_ack, dmem_rdata,
        input  dec_is_load, dec_is_store, dec_reg_we, dec_is_ecall,
        input  br_taken, alu_result, br_target,
        output pc, ir, alu_out, mdr, wb_sel, rf_we, retire, halted, fault
    );

    modport slave (
        input  imem_req,
        output imem_ack, imem_rdata,
        input  dmem_req, dmem_we,
        output dmem_ack, dmem_rdata,
        output dec_is_load, dec_is_store, dec_reg_we, dec_is_ecall,
        output br_taken, alu_result, br_target,
        input  pc, ir, alu_out, mdr, wb_sel, rf_we, retire, halted, fault
    );

endinterface

// File: rtl/seq_perf_cnt.sv
// Free-running cycle and retired-instruction counters, both wrapping at 2^32.
// Only instantiated by multicycle_seq when SEQ_PERF_EN is defined.
module seq_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        cnt_en_i,
    input  logic        retire_i,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instret_o
);

    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instret_q, instret_d;

    always_comb begin
        cycle_d   = cnt_en_i ? cycle_q + 32'd1 : cycle_q;
        instret_d = retire_i ? instret_q + 32'd1 : instret_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt_o = cycle_q;
    assign instret_o   = instret_q;

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB around a shared ALU.
// Optional SEQ_PERF_EN adds cycle_cnt/instret counter outputs.
module multicycle_seq
    import multicycle_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_seq_if.master   bus
`ifdef SEQ_PERF_EN
    ,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        instret
`endif
);

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic [31:0] mdr_q, mdr_d;
    logic        br_q, br_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;

    logic        in_fetch;
    logic        in_mem;
    logic        in_wb;
    logic        tgt_bad;
    logic        wb_commit;

    // Strobes come straight from the state register, with rst folded in so a
    // reset mid-handshake withdraws the request before the next edge.
    assign in_fetch  = (state_q == S_FETCH) && !rst;
    assign in_mem    = (state_q == S_MEM)   && !rst;
    assign in_wb     = (state_q == S_WB)    && !rst;
    assign tgt_bad   = br_q && is_misaligned(bus.br_target[1:0]);
    assign wb_commit = in_wb && !tgt_bad;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        br_d      = br_q;
        halted_d  = halted_q;
        fault_d   = fault_q;

        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (bus.dec_is_ecall) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_out_d = bus.alu_result;
                br_d      = bus.br_taken;
                state_d   = (bus.dec_is_load || bus.dec_is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (bus.dmem_ack) begin
                    if (bus.dec_is_load) begin
                        mdr_d = bus.dmem_rdata;
                    end
                    state_d = S_WB;
                end
            end
            S_WB: begin
                // A taken branch to a non-word address stops the core with PC intact.
                if (tgt_bad) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    pc_d    = br_q ? bus.br_target : pc_q + 32'd4;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_VECTOR;
            ir_q      <= NOP;
            alu_out_q <= 32'd0;
            mdr_q     <= 32'd0;
            br_q      <= 1'b0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
            br_q      <= br_d;
            halted_q  <= halted_d;
            fault_q   <= fault_d;
        end
    end

    assign bus.imem_req = in_fetch;
    assign bus.dmem_req = in_mem;
    assign bus.dmem_we  = in_mem && bus.dec_is_store;
    assign bus.rf_we    = wb_commit && bus.dec_reg_we && (ir_q[11:7] != 5'd0);
    assign bus.retire   = wb_commit;
    assign bus.wb_sel   = bus.dec_is_load ? WB_SEL_MEM : WB_SEL_ALU;
    assign bus.pc       = pc_q;
    assign bus.ir       = ir_q;
    assign bus.alu_out  = alu_out_q;
    assign bus.mdr      = mdr_q;
    assign bus.halted   = halted_q;
    assign bus.fault    = fault_q;

`ifdef SEQ_PERF_EN
    seq_perf_cnt u_perf (
        .clk         (clk),
        .rst         (rst),
        .cnt_en_i    (state_q != S_HALT),
        .retire_i    (wb_commit),
        .cycle_cnt_o (cycle_cnt),
        .instret_o   (instret)
    );
`endif

    a_one_mem_req: assert property (@(posedge clk) disable iff (rst)
        !(bus.imem_req && bus.dmem_req));
    a_we_needs_retire: assert property (@(posedge clk) disable iff (rst)
        bus.rf_we |-> bus.retire);

endmodule

// File: tb/tb_multicycle_seq.sv
// Bench for multicycle_seq: instruction-level model expands each directed instruction
// into a per-cycle trace of stimulus and expected outputs, checked every cycle.
module tb_multicycle_seq;
    import multicycle_seq_pkg::*;

    localparam logic [31:0] RV = 32'h0000_8000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multicycle_seq_if bus();
`ifdef SEQ_PERF_EN
    logic [31:0] cycle_cnt, instret;
`endif

    multicycle_seq #(.RESET_VECTOR(RV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SEQ_PERF_EN
        ,
        .cycle_cnt (cycle_cnt),
        .instret   (instret)
`endif
    );

    // cls = {load, store, reg_we, ecall, branch_taken}
    typedef struct {
        logic [31:0] instr;
        logic        ld, st, we, ecall, br;
        logic [31:0] alu, tgt, rdata;
        int          idly, ddly;
    } ins_t;

    typedef struct {
        logic        imem_ack;
        logic [31:0] imem_rdata;
        logic        dmem_ack;
        logic [31:0] dmem_rdata;
        logic        ld, st, we, ecall, br_taken;
        logic [31:0] alu_result, br_target;
        logic [4:0]  strb;   // {imem_req, dmem_req, dmem_we, rf_we, retire}
        logic        wb_sel;
        logic [31:0] pc, ir, alu_out, mdr;
        logic        halted, fault;
        logic [31:0] cyc, inst;
    } cyc_t;

    cyc_t tr[$];
    cyc_t cur;
    int   cur_k = -1;
    bit   chk_en = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ret, n_we, n_ireq, n_dwe, first_we;

    logic [31:0] m_pc, m_ir, m_alu, m_mdr, m_cyc, m_inst;
    logic        m_br, m_halted, m_fault;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (trace step %0d): got %h, expected %h", nm, cur_k, got, exp);
        end
    endtask

    function automatic ins_t mk(input logic [31:0] instr, input logic [4:0] cls,
                                input logic [31:0] alu, input logic [31:0] tgt,
                                input logic [31:0] rdata, input int idly, input int ddly);
        ins_t d;
        d.instr = instr;
        {d.ld, d.st, d.we, d.ecall, d.br} = cls;
        d.alu = alu; d.tgt = tgt; d.rdata = rdata;
        d.idly = idly; d.ddly = ddly;
        return d;
    endfunction

    task automatic model_reset();
        tr.delete();
        m_pc = RV; m_ir = NOP; m_alu = 32'd0; m_mdr = 32'd0;
        m_br = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
        m_cyc = 32'd1;  // the BOOT cycle is already counted when the trace starts
        m_inst = 32'd0;
    endtask

    function automatic cyc_t base(input ins_t d);
        cyc_t e;
        e.imem_ack = 1'b0; e.imem_rdata = 32'hBAD0_0000;
        e.dmem_ack = 1'b0; e.dmem_rdata = 32'h5A5A_0000;
        e.ld = d.ld; e.st = d.st; e.we = d.we; e.ecall = d.ecall;
        e.br_taken = !d.br; e.alu_result = ~d.alu; e.br_target = d.tgt;
        e.strb = 5'b00000; e.wb_sel = d.ld;
        e.pc = '0; e.ir = '0; e.alu_out = '0; e.mdr = '0;
        e.halted = 1'b0; e.fault = 1'b0; e.cyc = '0; e.inst = '0;
        return e;
    endfunction

    task automatic emit(input cyc_t e_in, input bit halt_cyc);
        cyc_t e;
        e = e_in;
        e.pc = m_pc; e.ir = m_ir; e.alu_out = m_alu; e.mdr = m_mdr;
        e.halted = m_halted; e.fault = m_fault; e.cyc = m_cyc; e.inst = m_inst;
        tr.push_back(e);
        if (!halt_cyc) m_cyc = m_cyc + 32'd1;
        if (e.strb[0]) m_inst = m_inst + 32'd1;
    endtask

    task automatic add_instr(input ins_t d);
        cyc_t e;
        logic mis;
        for (int j = 0; j <= d.idly; j++) begin
            e = base(d);
            e.strb = 5'b10000;
            if (j == d.idly) begin
                e.imem_ack = 1'b1;
                e.imem_rdata = d.instr;
            end else begin
                e.imem_rdata = 32'hBAD0_0000 + 32'(j);
            end
            emit(e, 1'b0);
        end
        m_ir = d.instr;
        e = base(d);
        e.dmem_ack = 1'b1;
        emit(e, 1'b0);
        if (d.ecall) begin
            m_halted = 1'b1;
            return;
        end
        e = base(d);
        e.alu_result = d.alu; e.br_taken = d.br;
        e.imem_ack = 1'b1; e.imem_rdata = 32'hBAD1_1111;
        emit(e, 1'b0);
        m_alu = d.alu;
        m_br = d.br;
        if (d.ld || d.st) begin
            for (int j = 0; j <= d.ddly; j++) begin
                e = base(d);
                e.strb = {1'b0, 1'b1, d.st, 2'b00};
                if (j == d.ddly) begin
                    e.dmem_ack = 1'b1;
                    e.dmem_rdata = d.rdata;
                end
                emit(e, 1'b0);
            end
            if (d.ld) m_mdr = d.rdata;
        end
        mis = m_br && (d.tgt[1:0] != 2'b00);
        e = base(d);
        e.strb = {3'b000, !mis && d.we && (d.instr[11:7] != 5'd0), !mis};
        emit(e, 1'b0);
        if (mis) m_fault = 1'b1;
        else     m_pc = m_br ? d.tgt : m_pc + 32'd4;
    endtask

    task automatic add_halt(input int n);
        cyc_t e;
        for (int j = 0; j < n; j++) begin
            e = base(mk(32'hFFFF_FFFF, 5'b11111, 32'h0, 32'h0000_8200, 32'h0, 0, 0));
            e.imem_ack = 1'b1; e.dmem_ack = 1'b1;
            e.imem_rdata = 32'hFFFF_FFFF; e.dmem_rdata = 32'hFFFF_FFFF;
            emit(e, 1'b1);
        end
    endtask

    task automatic drive(input cyc_t e);
        bus.imem_ack     = e.imem_ack;
        bus.imem_rdata   = e.imem_rdata;
        bus.dmem_ack     = e.dmem_ack;
        bus.dmem_rdata   = e.dmem_rdata;
        bus.dec_is_load  = e.ld;
        bus.dec_is_store = e.st;
        bus.dec_reg_we   = e.we;
        bus.dec_is_ecall = e.ecall;
        bus.br_taken     = e.br_taken;
        bus.alu_result   = e.alu_result;
        bus.br_target    = e.br_target;
    endtask

    task automatic drive_idle();
        cyc_t e;
        e = base(mk(32'h0, 5'b00000, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 0));
        drive(e);
    endtask

    task automatic clear_counts();
        n_ret = 0; n_we = 0; n_ireq = 0; n_dwe = 0; first_we = -1;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_strobes", 32'({bus.imem_req, bus.dmem_req, bus.dmem_we, bus.rf_we, bus.retire}), 32'd0);
        chk("rst_pc", bus.pc, RV);
        chk("rst_ir", bus.ir, NOP);
        chk("rst_alu_out", bus.alu_out, 32'd0);
        chk("rst_mdr", bus.mdr, 32'd0);
        chk("rst_halt_fault", 32'({bus.halted, bus.fault}), 32'd0);
`ifdef SEQ_PERF_EN
        chk("rst_cycle_cnt", cycle_cnt, 32'd0);
        chk("rst_instret", instret, 32'd0);
`endif
        rst = 1'b0;
    endtask

    task automatic run_trace(input int upto);
        for (int k = 0; k < upto; k++) begin
            @(posedge clk);
            #1;
            cur = tr[k];
            cur_k = k;
            drive(cur);
            chk_en = 1'b1;
        end
        @(negedge clk);
        #1;
        chk_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("strobes", 32'({bus.imem_req, bus.dmem_req, bus.dmem_we, bus.rf_we, bus.retire}),
                32'(cur.strb));
            if (cur.strb[1]) chk("wb_sel", 32'(bus.wb_sel), 32'(cur.wb_sel));
            chk("pc", bus.pc, cur.pc);
            chk("ir", bus.ir, cur.ir);
            chk("alu_out", bus.alu_out, cur.alu_out);
            chk("mdr", bus.mdr, cur.mdr);
            chk("halt_fault", 32'({bus.halted, bus.fault}), 32'({cur.halted, cur.fault}));
`ifdef SEQ_PERF_EN
            chk("cycle_cnt", cycle_cnt, cur.cyc);
            chk("instret", instret, cur.inst);
`endif
            if (bus.retire)   n_ret++;
            if (bus.imem_req) n_ireq++;
            if (bus.dmem_we)  n_dwe++;
            if (bus.rf_we) begin
                n_we++;
                if (first_we < 0) first_we = cur_k + 1;
            end
        end
    end

    initial begin
        drive_idle();
        #2;

        // Run A: ALU ops, slow fetch, load, store, taken branch, rd=x0, ecall.
        model_reset();
        add_instr(mk(32'h0050_0093, 5'b00100, 32'd5,         32'h0000_1234, 32'h0,         0, 0));
        add_instr(mk(32'h0010_8093, 5'b00100, 32'd6,         32'h0000_0003, 32'h0,         3, 0));
        add_instr(mk(32'h0000_A103, 5'b10100, 32'h0000_1000, 32'h0,         32'hDEAD_BEEF, 0, 2));
        add_instr(mk(32'h0020_A223, 5'b01000, 32'h0000_1004, 32'h0,         32'h1111_2222, 0, 1));
        add_instr(mk(32'h0E00_0C63, 5'b00001, 32'h0,         32'h0000_8100, 32'h0,         0, 0));
        add_instr(mk(32'h0010_0013, 5'b00100, 32'd1,         32'h0,         32'h0,         1, 0));
        add_instr(mk(32'h0000_0073, 5'b00010, 32'h0,         32'h0,         32'h0,         0, 0));
        add_halt(4);
        do_reset();
        clear_counts();
        run_trace(tr.size());
        chk("A_first_rf_we_cycle", 32'(first_we), 32'd4);
        chk("A_final_pc", bus.pc, 32'h0000_8104);
        chk("A_mdr", bus.mdr, 32'hDEAD_BEEF);
        chk("A_retires", 32'(n_ret), 32'd6);
        chk("A_rf_we_pulses", 32'(n_we), 32'd3);
        chk("A_imem_req_cycles", 32'(n_ireq), 32'd11);
        chk("A_dmem_we_cycles", 32'(n_dwe), 32'd2);
        chk("A_halted", 32'({bus.halted, bus.fault}), 32'b10);

        // Run B: aligned taken branch, then a writing jump to a misaligned target.
        model_reset();
        add_instr(mk(32'h0E00_0C63, 5'b00001, 32'h0,  32'h0000_8100, 32'h0, 0, 0));
        add_instr(mk(32'h1000_00EF, 5'b00101, 32'h44, 32'h0000_8102, 32'h0, 0, 0));
        add_halt(3);
        do_reset();
        clear_counts();
        run_trace(tr.size());
        chk("B_pc", bus.pc, 32'h0000_8100);
        chk("B_fault", 32'({bus.halted, bus.fault}), 32'b01);
        chk("B_rf_we_pulses", 32'(n_we), 32'd0);
        chk("B_retires", 32'(n_ret), 32'd1);

        // Run C: reset lands while a load is waiting in MEM.
        model_reset();
        add_instr(mk(32'h0050_0093, 5'b00100, 32'd5,         32'h0, 32'h0,         0, 0));
        add_instr(mk(32'h0000_A103, 5'b10100, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 0, 10));
        do_reset();
        clear_counts();
        run_trace(9);
        chk("C_pre_dmem_req", 32'(bus.dmem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("C_rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("C_rst_pc", bus.pc, RV);
        chk("C_rst_ir", bus.ir, NOP);
        chk("C_rst_mdr", bus.mdr, 32'd0);
        chk("C_rst_alu_out", bus.alu_out, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("C_boot_imem_req", 32'(bus.imem_req), 32'd0);
        @(posedge clk);
        #1;
        chk("C_fetch_imem_req", 32'(bus.imem_req), 32'd1);
`ifdef SEQ_PERF_EN
        chk("C_cycle_cnt", cycle_cnt, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_seq.md
# multicycle_seq

Multi-cycle control sequencer for the non-pipelined RV32I core. It steps each instruction through fetch, decode, execute, optional memory access and writeback around the shared ALU. It owns PC, IR and the ALU-result/memory-data latches, and runs the instruction- and data-memory request/acknowledge handshakes. The decoder, register file and branch-target adder sit outside and exchange signals with this block.

## Interface
- RESET_VECTOR, 32'h0000_0000: PC loaded on reset.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch complete; imem_rdata valid.
- imem_rdata  in  32  fetched instruction.
- dmem_req / dmem_we  out  1 / 1  data access request / write.
- dmem_ack  in  1  data access complete.
- dmem_rdata  in  32  load data.
- dec_is_load / dec_is_store / dec_reg_we / dec_is_ecall  in  1  decoder class flags for the current IR.
- br_taken  in  1  ALU branch decision.
- alu_result  in  32  ALU output.
- br_target  in  32  external target adder output.
- pc / ir  out  32  current PC / latched instruction.
- alu_out / mdr  out  32  latched ALU result (also the data address) / latched load data.
- wb_sel  out  1  register-file write source: 0 alu_out, 1 mdr.
- rf_we  out  1  register-file write strobe.
- retire  out  1  one-cycle pulse per completed instruction.
- halted / fault  out  1  stopped after ecall / stopped after misaligned target.

## Operation
- States: BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset (async): state BOOT, pc=RESET_VECTOR, ir=32'h0000_0013 (NOP), alu_out=mdr=0, all strobes, halted and fault 0.
- BOOT: one cycle, then FETCH.
- FETCH: imem_req=1 combinationally. On imem_ack: ir<=imem_rdata and go to DECODE. Otherwise stay, with imem_req held high.
- DECODE: one cycle for decoder and register-file read.
  - If dec_is_ecall: go to HALT and set halted.
- EXEC: alu_out<=alu_result and br_taken is latched.
  - Load or store: go to MEM.
  - Otherwise: go to WB.
- MEM: dmem_req=1, and dmem_we=dec_is_store. Both stay stable until dmem_ack. On ack: if load, mdr<=dmem_rdata; then go to WB.
- WB:
  - rf_we = dec_reg_we and ir[11:7]≠0.
  - wb_sel = dec_is_load.
  - retire=1.
  - If the latched br_taken is set: pc<=br_target; otherwise pc<=pc+4, wrapping modulo 2^32.
  - Next state FETCH.
- Misaligned target: taken branch with br_target[1:0]≠0 in WB means rf_we=0, retire=0, pc unchanged, fault=1, state HALT.
- HALT: absorbing; all requests 0; only rst leaves it.
- Ignored inputs: imem_ack outside FETCH and dmem_ack outside MEM.

## Timing
- rf_we, retire, imem_req, dmem_req and dmem_we are decoded from the state register. They are glitch-free relative to clk and forced to 0 asynchronously by rst.
- With same-cycle acks, ALU/branch instructions take 4 cycles (FETCH, DECODE, EXEC, WB) and load/store take 5.
- Each extra cycle of ack latency adds one cycle.
- Reset asserted mid-FETCH or mid-MEM drops the request in the same cycle. No partial ir or mdr update.
- pc is updated on the WB→FETCH edge; the next imem_req carries the new pc.

## Configuration
- SEQ_PERF_EN defined: adds outputs cycle_cnt[31:0] and instret[31:0], both reset to 0.
  - cycle_cnt increments every non-HALT cycle.
  - instret increments on each retire.
  - Both wrap at 2^32.
- SEQ_PERF_EN undefined: those ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package holds:
  - State encoding constants, 3-bit: BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
  - NOP constant 32'h0000_0013.
  - WB_SEL_ALU / WB_SEL_MEM.
- Sub-module seq_perf_cnt holds both counters and is instantiated only under SEQ_PERF_EN.

## Test plan
- RESET_VECTOR=0x8000, imem_ack tied high, ir=ADDI x1,x0,5, no branch:
  - rf_we pulses in cycle 4 after BOOT.
  - pc becomes 0x8004.
  - retire pulses once.
- imem_ack delayed 3 cycles: imem_req stays high 4 cycles; ir changes only on the ack cycle; total 7 cycles.
- Load with dmem_ack 2 cycles after dmem_req and dmem_rdata=0xDEADBEEF:
  - mdr=0xDEADBEEF.
  - wb_sel=1 during the rf_we pulse.
  - dmem_we=0 throughout.
- Taken branch, br_target=0x8100: pc=0x8100. Then br_target=0x8102: HALT, fault=1, no rf_we, pc unchanged.
- ADDI with rd=x0: rf_we stays 0 and retire still pulses. Then ecall: halted=1 and no further imem_req.
- rst asserted while in MEM with dmem_req=1: dmem_req drops in the same cycle, pc=RESET_VECTOR. After release, BOOT then FETCH.
